// File: rtl/rvvi_pkg.sv
// rvvi_pkg: shared constants and popcount helper for the RVVI trace monitor
package rvvi_pkg;
    localparam int CNTW_DEF = 64;
    localparam int COV_BITS = 107;
    localparam logic [4:0] OPC_LOAD   = 5'd0;
    localparam logic [4:0] OPC_OP_IMM = 5'd4;
    localparam logic [4:0] OPC_AUIPC  = 5'd5;
    localparam logic [4:0] OPC_STORE  = 5'd8;
    localparam logic [4:0] OPC_OP     = 5'd12;
    localparam logic [4:0] OPC_LUI    = 5'd13;
    localparam logic [4:0] OPC_BRANCH = 5'd24;
    localparam logic [4:0] OPC_JALR   = 5'd25;
    localparam logic [4:0] OPC_JAL    = 5'd27;
    localparam logic [4:0] OPC_SYSTEM = 5'd28;
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    function automatic logic [7:0] popcount(input logic [COV_BITS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < COV_BITS; i++) n = n + 8'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/rvvi_sat_counter.sv
// rvvi_sat_counter: saturating up-counter with enable and async active-low clear
module rvvi_sat_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/rvvi_trace.sv
// rvvi_trace: RVVI retirement-trace monitor with sticky coverage bitmaps, event counters and protocol checks
module rvvi_trace
    import rvvi_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int FLEN = 64,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid,
    input  logic [63:0]     order,
    input  logic [31:0]     insn,
    input  logic            trap,
    input  logic            debug_mode,
    input  logic [XLEN-1:0] pc_rdata,
    input  logic [1:0]      mode,
    input  logic            m_ext_intr,
    input  logic            s_ext_intr,
    input  logic            m_timer_intr,
    input  logic            m_soft_intr,
    input  logic [31:0]     x_wb,
    input  logic [31:0]     f_wb,
    output logic [CNTW-1:0] retired_cnt,
    output logic [CNTW-1:0] trap_cnt,
    output logic [CNTW-1:0] debug_cnt,
    output logic [31:0]     opcode_hit,
    output logic [2:0]      cq_hit,
    output logic [3:0]      mode_hit,
    output logic [3:0]      intr_hit,
    output logic [31:0]     xreg_hit,
    output logic [31:0]     freg_hit,
    output logic [7:0]      cov_total,
    output logic            order_err,
    output logic            pc_align_err
);
    logic        first_seen;
    logic [63:0] last_order;
    logic        unused;

    rvvi_sat_counter #(.W(CNTW)) u_retired (.clk(clk), .reset_n(reset_n), .en(valid && !trap), .cnt(retired_cnt));
    rvvi_sat_counter #(.W(CNTW)) u_trap    (.clk(clk), .reset_n(reset_n), .en(valid && trap), .cnt(trap_cnt));
    rvvi_sat_counter #(.W(CNTW)) u_debug   (.clk(clk), .reset_n(reset_n), .en(valid && debug_mode), .cnt(debug_cnt));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_hit   <= '0;
            cq_hit       <= '0;
            mode_hit     <= '0;
            intr_hit     <= '0;
            xreg_hit     <= '0;
            freg_hit     <= '0;
            order_err    <= 1'b0;
            pc_align_err <= 1'b0;
            first_seen   <= 1'b0;
            last_order   <= '0;
        end else if (valid) begin
            if (!trap) begin
                if (insn[1:0] == 2'b11) opcode_hit[insn[6:2]] <= 1'b1;
                else cq_hit[insn[1:0]] <= 1'b1;
                xreg_hit <= xreg_hit | {x_wb[31:1], 1'b0};
                freg_hit <= freg_hit | f_wb;
            end
            if (!debug_mode) mode_hit[mode] <= 1'b1;
            intr_hit <= intr_hit | {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr};
            // last_order+1 wraps naturally at 64 bits, so all-ones -> 0 is in sequence
            if (first_seen && order != last_order + 64'd1) order_err <= 1'b1;
            if (pc_rdata[0]) pc_align_err <= 1'b1;
            first_seen <= 1'b1;
            last_order <= order;
        end
    end

    assign cov_total = popcount({opcode_hit, cq_hit, mode_hit, intr_hit, xreg_hit, freg_hit});
    assign unused = ^{insn[31:7], pc_rdata[XLEN-1:1], 32'(FLEN)};
endmodule

// File: tb/tb_rvvi_trace.sv
// tb_rvvi_trace: randomized and directed checks of rvvi_trace against a behavioural model
module tb_rvvi_trace;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] order = '0;
    logic [31:0] insn = '0;
    logic        trap = 1'b0;
    logic        debug_mode = 1'b0;
    logic [63:0] pc_rdata = '0;
    logic [1:0]  mode = '0;
    logic        m_ext_intr = 1'b0, s_ext_intr = 1'b0, m_timer_intr = 1'b0, m_soft_intr = 1'b0;
    logic [31:0] x_wb = '0, f_wb = '0;

    logic [7:0]  retired_cnt, trap_cnt, debug_cnt;
    logic [31:0] opcode_hit, xreg_hit, freg_hit;
    logic [2:0]  cq_hit;
    logic [3:0]  mode_hit, intr_hit;
    logic [7:0]  cov_total;
    logic        order_err, pc_align_err;

    logic [3:0]  s_retired_cnt, s_trap_cnt, s_debug_cnt;
    logic [31:0] s_opcode_hit, s_xreg_hit, s_freg_hit;
    logic [2:0]  s_cq_hit;
    logic [3:0]  s_mode_hit, s_intr_hit;
    logic [7:0]  s_cov_total;
    logic        s_order_err, s_pc_align_err;

    int tests = 0, fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    rvvi_trace #(.XLEN(64), .FLEN(64), .CNTW(8)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .order(order), .insn(insn), .trap(trap),
        .debug_mode(debug_mode), .pc_rdata(pc_rdata), .mode(mode), .m_ext_intr(m_ext_intr),
        .s_ext_intr(s_ext_intr), .m_timer_intr(m_timer_intr), .m_soft_intr(m_soft_intr),
        .x_wb(x_wb), .f_wb(f_wb), .retired_cnt(retired_cnt), .trap_cnt(trap_cnt),
        .debug_cnt(debug_cnt), .opcode_hit(opcode_hit), .cq_hit(cq_hit), .mode_hit(mode_hit),
        .intr_hit(intr_hit), .xreg_hit(xreg_hit), .freg_hit(freg_hit), .cov_total(cov_total),
        .order_err(order_err), .pc_align_err(pc_align_err));

    rvvi_trace #(.XLEN(32), .FLEN(32), .CNTW(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .valid(valid), .order(order), .insn(insn), .trap(trap),
        .debug_mode(debug_mode), .pc_rdata(pc_rdata[31:0]), .mode(mode), .m_ext_intr(m_ext_intr),
        .s_ext_intr(s_ext_intr), .m_timer_intr(m_timer_intr), .m_soft_intr(m_soft_intr),
        .x_wb(x_wb), .f_wb(f_wb), .retired_cnt(s_retired_cnt), .trap_cnt(s_trap_cnt),
        .debug_cnt(s_debug_cnt), .opcode_hit(s_opcode_hit), .cq_hit(s_cq_hit), .mode_hit(s_mode_hit),
        .intr_hit(s_intr_hit), .xreg_hit(s_xreg_hit), .freg_hit(s_freg_hit), .cov_total(s_cov_total),
        .order_err(s_order_err), .pc_align_err(s_pc_align_err));

    // behavioural model: raw event totals, saturated only when compared
    longint unsigned n_ret = 0, n_trap = 0, n_dbg = 0;
    logic [31:0] m_opc = '0, m_x = '0, m_f = '0;
    logic [2:0]  m_cq = '0;
    logic [3:0]  m_mode = '0, m_intr = '0;
    bit          m_first = 1'b0, m_oerr = 1'b0, m_perr = 1'b0;
    logic [63:0] m_last = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_ret = 0; n_trap = 0; n_dbg = 0;
            m_opc = '0; m_x = '0; m_f = '0; m_cq = '0; m_mode = '0; m_intr = '0;
            m_first = 1'b0; m_oerr = 1'b0; m_perr = 1'b0; m_last = '0;
        end else if (valid) begin
            if (trap) n_trap++; else n_ret++;
            if (debug_mode) n_dbg++;
            if (!trap) begin
                if (insn[1:0] == 2'b11) m_opc[insn[6:2]] = 1'b1;
                else m_cq[insn[1:0]] = 1'b1;
                m_x = m_x | (x_wb & ~32'h1);
                m_f = m_f | f_wb;
            end
            if (!debug_mode) m_mode[mode] = 1'b1;
            if (m_ext_intr) m_intr[0] = 1'b1;
            if (s_ext_intr) m_intr[1] = 1'b1;
            if (m_timer_intr) m_intr[2] = 1'b1;
            if (m_soft_intr) m_intr[3] = 1'b1;
            if (m_first && order != m_last + 64'd1) m_oerr = 1'b1;
            if (pc_rdata[0]) m_perr = 1'b1;
            m_first = 1'b1;
            m_last = order;
        end
    end

    function automatic logic [63:0] sat(input longint unsigned n, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (n > mx) ? mx : n;
    endfunction

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) if (chk_on) begin
        check("retired_cnt", 64'(retired_cnt), sat(n_ret, 8));
        check("trap_cnt", 64'(trap_cnt), sat(n_trap, 8));
        check("debug_cnt", 64'(debug_cnt), sat(n_dbg, 8));
        check("opcode_hit", 64'(opcode_hit), 64'(m_opc));
        check("cq_hit", 64'(cq_hit), 64'(m_cq));
        check("mode_hit", 64'(mode_hit), 64'(m_mode));
        check("intr_hit", 64'(intr_hit), 64'(m_intr));
        check("xreg_hit", 64'(xreg_hit), 64'(m_x));
        check("freg_hit", 64'(freg_hit), 64'(m_f));
        check("cov_total", 64'(cov_total), 64'($countones({m_opc, m_cq, m_mode, m_intr, m_x, m_f})));
        check("order_err", 64'(order_err), 64'(m_oerr));
        check("pc_align_err", 64'(pc_align_err), 64'(m_perr));
        check("s_retired_cnt", 64'(s_retired_cnt), sat(n_ret, 4));
        check("s_trap_cnt", 64'(s_trap_cnt), sat(n_trap, 4));
        check("s_debug_cnt", 64'(s_debug_cnt), sat(n_dbg, 4));
        check("s_cov_total", 64'(s_cov_total), 64'(cov_total));
        check("s_order_err", 64'(s_order_err), 64'(m_oerr));
        check("s_pc_align_err", 64'(s_pc_align_err), 64'(m_perr));
    end

    task automatic put(input logic v, input logic [63:0] o, input logic [31:0] i, input logic t,
                       input logic d, input logic [63:0] pc, input logic [1:0] m,
                       input logic [3:0] irq, input logic [31:0] xw, input logic [31:0] fw);
        valid = v; order = o; insn = i; trap = t; debug_mode = d; pc_rdata = pc; mode = m;
        {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr} = irq;
        x_wb = xw; f_wb = fw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_retired_cnt", 64'(retired_cnt), 64'd0);
        check("rst_cov_total", 64'(cov_total), 64'd0);
        check("rst_errs", 64'({order_err, pc_align_err}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] ord;
        logic v;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_on = 1'b1;
        check("init_trap_cnt", 64'(trap_cnt), 64'd0);
        check("init_opcode_hit", 64'(opcode_hit), 64'd0);

        // mid-stream reset, then a fresh first record
        for (int k = 0; k < 5; k++)
            put(1'b1, 64'(k + 1), 32'h00000033, 1'b0, 1'b0, 64'h2000, 2'd3, 4'h1, 32'h8, 32'h4);
        do_reset();
        check("post_rst_intr", 64'(intr_hit), 64'd0);
        put(1'b1, 64'd100, 32'h00000013, 1'b0, 1'b0, 64'h2000, 2'd0, 4'h0, 32'h0, 32'h0);
        check("first_after_rst_order_err", 64'(order_err), 64'd0);
        check("first_after_rst_retired", 64'(retired_cnt), 64'd1);

        // retired addi, trapped ecall, compressed c.li
        do_reset();
        put(1'b1, 64'd1, 32'h00500093, 1'b0, 1'b0, 64'h1000, 2'd3, 4'h0, 32'h2, 32'h0);
        check("addi_retired", 64'(retired_cnt), 64'd1);
        check("addi_opcode_hit", 64'(opcode_hit), 64'h10);
        check("addi_mode_hit", 64'(mode_hit), 64'h8);
        check("addi_xreg_hit", 64'(xreg_hit), 64'h2);
        check("addi_cov_total", 64'(cov_total), 64'd3);
        check("model_cov_total", 64'($countones({m_opc, m_cq, m_mode, m_intr, m_x, m_f})), 64'd3);
        put(1'b1, 64'd2, 32'h00000073, 1'b1, 1'b0, 64'h1004, 2'd3, 4'h0, 32'h1, 32'h0);
        check("ecall_trap_cnt", 64'(trap_cnt), 64'd1);
        check("ecall_retired", 64'(retired_cnt), 64'd1);
        check("ecall_opcode_hit", 64'(opcode_hit), 64'h10);
        check("ecall_xreg_hit", 64'(xreg_hit), 64'h2);
        check("model_trap", 64'(n_trap), 64'd1);
        put(1'b1, 64'd3, 32'h00004501, 1'b0, 1'b0, 64'h1008, 2'd3, 4'h0, 32'h0, 32'h0);
        check("cli_cq_hit", 64'(cq_hit), 64'h2);
        check("cli_cov_total", 64'(cov_total), 64'd4);

        // order sequencing and 64-bit wrap
        do_reset();
        put(1'b1, 64'd7, 32'h00000013, 1'b0, 1'b0, 64'h0, 2'd1, 4'h0, 32'h0, 32'h0);
        put(1'b1, 64'd8, 32'h00000013, 1'b0, 1'b0, 64'h4, 2'd1, 4'h0, 32'h0, 32'h0);
        check("order_8", 64'(order_err), 64'd0);
        put(1'b1, 64'd10, 32'h00000013, 1'b0, 1'b0, 64'h8, 2'd1, 4'h0, 32'h0, 32'h0);
        check("order_10", 64'(order_err), 64'd1);
        put(1'b1, 64'd11, 32'h00000013, 1'b0, 1'b0, 64'hc, 2'd1, 4'h0, 32'h0, 32'h0);
        check("order_11_sticky", 64'(order_err), 64'd1);
        do_reset();
        put(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h00000013, 1'b0, 1'b0, 64'h0, 2'd1, 4'h0, 32'h0, 32'h0);
        put(1'b1, 64'd0, 32'h00000013, 1'b0, 1'b0, 64'h4, 2'd1, 4'h0, 32'h0, 32'h0);
        check("order_wrap", 64'(order_err), 64'd0);

        // saturation of the narrow instance, then trap+debug together
        do_reset();
        for (int k = 0; k < 20; k++)
            put(1'b1, 64'(k), 32'h00000013, 1'b0, 1'b0, 64'h0, 2'd3, 4'h0, 32'h0, 32'h0);
        check("sat_s_retired", 64'(s_retired_cnt), 64'hF);
        check("sat_retired", 64'(retired_cnt), 64'd20);
        put(1'b1, 64'd20, 32'h00000073, 1'b1, 1'b1, 64'h0, 2'd3, 4'h0, 32'h0, 32'h0);
        check("trapdbg_trap", 64'(trap_cnt), 64'd1);
        check("trapdbg_debug", 64'(debug_cnt), 64'd1);

        // interrupt and misaligned pc, then idle cycles with toggling inputs
        do_reset();
        put(1'b1, 64'd0, 32'h00000013, 1'b0, 1'b0, 64'h8000_0001, 2'd0, 4'h4, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++)
            put(1'b0, {$urandom, $urandom}, $urandom, 1'($urandom), 1'($urandom), {$urandom, $urandom},
                2'($urandom), 4'($urandom), $urandom, $urandom);
        check("irq_intr_hit", 64'(intr_hit), 64'h4);
        check("irq_pc_align", 64'(pc_align_err), 64'd1);
        check("idle_retired", 64'(retired_cnt), 64'd1);
        check("idle_cov_total", 64'(cov_total), 64'd3);

        // mode=2 reserved detector
        put(1'b1, 64'd1, 32'h00000013, 1'b0, 1'b0, 64'h0, 2'd2, 4'h0, 32'h0, 32'h0);
        check("mode2_hit", 64'(mode_hit), 64'h5);

        // randomized traffic
        do_reset();
        ord = {$urandom, $urandom};
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(499) == 0) do_reset();
            v = ($urandom_range(3) != 0);
            ord = ($urandom_range(9) == 0) ? {$urandom, $urandom} : ord + 64'd1;
            put(v, ord, $urandom, ($urandom_range(4) == 0), ($urandom_range(6) == 0),
                {$urandom, $urandom[31:1], ($urandom_range(99) == 0)}, 2'($urandom_range(3)),
                ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'h0,
                ($urandom_range(3) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0,
                ($urandom_range(3) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0);
        end
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
